// File: rtl/load_aligner_pkg.sv
// Shared opcode and FSM state encodings for the load aligner, plus small
// opcode-decoding helpers used by the top level.
package load_aligner_pkg;

  typedef enum logic [2:0] {
    ME_LW  = 3'd0,
    ME_LH  = 3'd1,
    ME_LHU = 3'd2,
    ME_LB  = 3'd3,
    ME_LBU = 3'd4,
    ME_LWU = 3'd5,
    ME_LD  = 3'd6
  } mem_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } la_state_e;

  // Access size in bytes; 0 for encodings that are not loads at all.
  function automatic logic [3:0] op_size(input logic [2:0] op);
    case (op)
      ME_LB, ME_LBU:         op_size = 4'd1;
      ME_LH, ME_LHU:         op_size = 4'd2;
      ME_LW, ME_LWU:         op_size = 4'd4;
      ME_LD:                 op_size = 4'd8;
      default:               op_size = 4'd0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op, input int dw);
    case (op)
      ME_LW, ME_LH, ME_LHU, ME_LB, ME_LBU: op_legal = 1'b1;
      ME_LWU, ME_LD:                       op_legal = (dw == 64);
      default:                             op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner_extract.sv
// Combinational lane selection and sign/zero extension of a loaded value
// from one beat or from two merged beats ({beat2, beat1}).
module load_extract
  import load_aligner_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]              op_i,
  input  logic [$clog2(DW/8)-1:0] off_i,
  input  logic [2*DW-1:0]         data_i,
  output logic [DW-1:0]           res_o
);

  logic [DW-1:0]      shifted;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;
  logic signed [31:0] w_s;

  // Byte k of the access lands in lane k after shifting out the offset.
  assign shifted = DW'(data_i >> {off_i, 3'b000});
  assign b_s     = shifted[7:0];
  assign h_s     = shifted[15:0];
  assign w_s     = shifted[31:0];

  always_comb begin
    res_o = '0;
    case (op_i)
      ME_LB:   res_o = DW'(b_s);
      ME_LBU:  res_o = DW'(shifted[7:0]);
      ME_LH:   res_o = DW'(h_s);
      ME_LHU:  res_o = DW'(shifted[15:0]);
      ME_LW:   res_o = DW'(w_s);
      ME_LWU:  res_o = DW'(shifted[31:0]);
      ME_LD:   res_o = shifted;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/load_aligner.sv
// Load aligner: turns a byte-addressed load into one or two aligned memory
// beats and returns the extended result on a registered response channel.
module load_aligner
  import load_aligner_pkg::*;
#(
  parameter int DW              = 32,
  parameter bit ALLOW_UNALIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [31:0]   req_addr,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [31:0]   mem_addr,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err
);

  localparam int          NB   = DW / 8;
  localparam int          OW   = $clog2(NB);
  localparam logic [31:0] NB32 = 32'(NB);

  la_state_e     state_q, state_d;
  logic [2:0]    op_q;
  logic [OW-1:0] off_q;
  logic          split_q;
  logic [31:0]   addr_q;
  logic [DW-1:0] beat1_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_err_q;

  logic            accept;
  logic            mem_hs;
  logic [OW-1:0]   req_off;
  logic            req_split;
  logic            req_err;
  logic            beat1_done;
  logic            last_beat_done;
  logic [2*DW-1:0] merged;
  logic [DW-1:0]   extracted;

  assign accept    = req_valid && req_ready;
  assign mem_hs    = mem_req_valid && mem_req_ready;
  assign req_off   = req_addr[OW-1:0];
  assign req_split = (32'(req_off) + 32'(op_size(req_op))) > NB32;
  assign req_err   = !op_legal(req_op, DW) || (req_split && !ALLOW_UNALIGNED);

  assign beat1_done     = (state_q == WAIT1) && mem_rsp_valid;
  assign last_beat_done = (beat1_done && !split_q) || ((state_q == WAIT2) && mem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = req_err ? DONE : REQ1;
      REQ1:    if (mem_hs)        state_d = WAIT1;
      WAIT1:   if (mem_rsp_valid) state_d = split_q ? REQ2 : DONE;
      REQ2:    if (mem_hs)        state_d = WAIT2;
      WAIT2:   if (mem_rsp_valid) state_d = DONE;
      DONE:    if (rsp_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE);
    mem_req_valid = (state_q == REQ1) || (state_q == REQ2);
    rsp_valid     = (state_q == DONE);
  end

  // Per-access context; only meaningful while an access is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= req_op;
      off_q   <= req_off;
      split_q <= req_split;
    end
    if (beat1_done) beat1_q <= mem_rdata;
  end

  // Second-beat upper half is don't-care for single-beat accesses.
  assign merged = (state_q == WAIT2) ? {mem_rdata, beat1_q} : {{DW{1'b0}}, mem_rdata};

  load_extract #(.DW(DW)) u_extract (
    .op_i   (op_q),
    .off_i  (off_q),
    .data_i (merged),
    .res_o  (extracted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr & ~(NB32 - 32'd1);
        rsp_data_q <= '0;
        rsp_err_q  <= req_err;
      end
      if (beat1_done && split_q) addr_q <= addr_q + NB32;
      if (last_beat_done) rsp_data_q <= extracted;
    end
  end

  assign mem_addr = addr_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_load_aligner.sv
// Directed bench for load_aligner: three configurations share one stimulus
// port, checked every cycle against a byte-addressed memory model.
module tb_load_aligner;
  import load_aligner_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;          // 0: DW32 split ok, 1: DW32 split error, 2: DW64
  logic        c_req_valid;
  logic [2:0]  c_req_op;
  logic [31:0] c_req_addr;
  logic        c_mem_req_ready;
  logic        c_rsp_ready;
  logic        auto_rsp_valid;
  logic [63:0] auto_rdata;
  logic        spur_valid;
  logic [63:0] spur_rdata;
  logic        hold_rsp;
  logic        c_mem_rsp_valid;
  logic [63:0] c_mem_rdata;

  logic [2:0]  i_req_valid, i_req_ready, i_mem_req_valid, i_mem_rsp_valid;
  logic [2:0]  i_rsp_valid, i_rsp_err;
  logic [31:0] i_mem_addr [3];
  logic [31:0] d0_rsp, d1_rsp;
  logic [63:0] d2_rsp;

  logic        c_req_ready, c_mem_req_valid, c_rsp_valid, c_rsp_err;
  logic [31:0] c_mem_addr;
  logic [63:0] c_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  assign c_mem_rsp_valid = auto_rsp_valid | spur_valid;
  assign c_mem_rdata     = spur_valid ? spur_rdata : auto_rdata;
  assign i_req_valid     = {sel == 2, sel == 1, sel == 0} & {3{c_req_valid}};
  assign i_mem_rsp_valid = {sel == 2, sel == 1, sel == 0} & {3{c_mem_rsp_valid}};

  always_comb begin
    c_req_ready     = i_req_ready[sel];
    c_mem_req_valid = i_mem_req_valid[sel];
    c_mem_addr      = i_mem_addr[sel];
    c_rsp_valid     = i_rsp_valid[sel];
    c_rsp_err       = i_rsp_err[sel];
    c_rsp_data      = {32'd0, d0_rsp};
    if (sel == 1)      c_rsp_data = {32'd0, d1_rsp};
    else if (sel == 2) c_rsp_data = d2_rsp;
  end

  load_aligner #(.DW(32), .ALLOW_UNALIGNED(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(i_req_valid[0]), .req_ready(i_req_ready[0]),
    .req_op(c_req_op), .req_addr(c_req_addr), .mem_req_valid(i_mem_req_valid[0]),
    .mem_req_ready(c_mem_req_ready), .mem_addr(i_mem_addr[0]),
    .mem_rsp_valid(i_mem_rsp_valid[0]), .mem_rdata(c_mem_rdata[31:0]),
    .rsp_valid(i_rsp_valid[0]), .rsp_ready(c_rsp_ready), .rsp_data(d0_rsp),
    .rsp_err(i_rsp_err[0]));

  load_aligner #(.DW(32), .ALLOW_UNALIGNED(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(i_req_valid[1]), .req_ready(i_req_ready[1]),
    .req_op(c_req_op), .req_addr(c_req_addr), .mem_req_valid(i_mem_req_valid[1]),
    .mem_req_ready(c_mem_req_ready), .mem_addr(i_mem_addr[1]),
    .mem_rsp_valid(i_mem_rsp_valid[1]), .mem_rdata(c_mem_rdata[31:0]),
    .rsp_valid(i_rsp_valid[1]), .rsp_ready(c_rsp_ready), .rsp_data(d1_rsp),
    .rsp_err(i_rsp_err[1]));

  load_aligner #(.DW(64), .ALLOW_UNALIGNED(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(i_req_valid[2]), .req_ready(i_req_ready[2]),
    .req_op(c_req_op), .req_addr(c_req_addr), .mem_req_valid(i_mem_req_valid[2]),
    .mem_req_ready(c_mem_req_ready), .mem_addr(i_mem_addr[2]),
    .mem_rsp_valid(i_mem_rsp_valid[2]), .mem_rdata(c_mem_rdata),
    .rsp_valid(i_rsp_valid[2]), .rsp_ready(c_rsp_ready), .rsp_data(d2_rsp),
    .rsp_err(i_rsp_err[2]));

  // ---------------- memory model ----------------
  logic [63:0] mem [logic [31:0]];

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a ^ 32'hA5C3_0F96, ~a + 32'h1357_9BDF};
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a, input int nb);
    logic [31:0] base;
    logic [63:0] w;
    int          lane;
    base = a & ~(32'(nb) - 32'd1);
    lane = int'(a & 32'(nb - 1));
    w    = mem_word(base);
    return w[8*lane +: 8];
  endfunction

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          beats;
    logic [31:0] a1;
    logic [31:0] a2;
  } exp_t;

  // Result = bytes addr..addr+size-1 read little-endian, then extended.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr,
                                 input int dw, input bit au);
    exp_t        m;
    int          nb;
    int          size;
    int          off;
    bit          sgn;
    bit          legal;
    logic [63:0] v;
    nb = dw / 8;
    sgn = 1'b0;
    case (op)
      3'd0:    begin size = 4; sgn = 1'b1; end
      3'd1:    begin size = 2; sgn = 1'b1; end
      3'd2:    size = 2;
      3'd3:    begin size = 1; sgn = 1'b1; end
      3'd4:    size = 1;
      3'd5:    size = 4;
      3'd6:    begin size = 8; sgn = 1'b1; end
      default: size = 0;
    endcase
    legal = (op <= 3'd4) || (dw == 64 && (op == 3'd5 || op == 3'd6));
    off   = int'(addr & 32'(nb - 1));
    m.a1  = addr & ~32'(nb - 1);
    m.a2  = m.a1 + 32'(nb);
    if (!legal || ((off + size > nb) && !au)) begin
      m.data = '0; m.err = 1'b1; m.beats = 0;
      return m;
    end
    v = '0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = mem_byte(addr + 32'(i), nb);
    if (sgn && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8*size));
    if (dw == 32) v[63:32] = 32'd0;
    m.data = v; m.err = 1'b0; m.beats = (off + size > nb) ? 2 : 1;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] pend_q[$];
  int          n_beats = 0;
  logic [31:0] last_beat_addr = '0;

  always @(posedge clk) begin
    if (!rst && c_mem_req_valid && c_mem_req_ready) begin
      pend_q.push_back(c_mem_addr);
      n_beats++;
      last_beat_addr = c_mem_addr;
    end
    #1;
    if (!hold_rsp && pend_q.size() > 0) begin
      auto_rsp_valid = 1'b1;
      auto_rdata     = mem_word(pend_q.pop_front());
    end else begin
      auto_rsp_valid = 1'b0;
      auto_rdata     = '0;
    end
  end

  // ---------------- compare process ----------------
  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [63:0] last_data = '0;
  logic        last_err  = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (c_mem_req_valid) begin
        if (exp_addr_q.size() == 0) check("mem_req_unexpected", c_mem_req_valid, 0);
        else begin
          check("mem_addr", c_mem_addr, exp_addr_q[0]);
          if (c_mem_req_ready) void'(exp_addr_q.pop_front());
        end
      end
      if (c_rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_unexpected", c_rsp_valid, 0);
        else begin
          check("rsp_data", c_rsp_data, exp_q[0].data);
          check("rsp_err", c_rsp_err, exp_q[0].err);
          if (c_rsp_ready) begin
            last_data = c_rsp_data;
            last_err  = c_rsp_err;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dw_of(input int s);
    return (s == 2) ? 64 : 32;
  endfunction

  task automatic issue(input int s, input logic [2:0] op, input logic [31:0] addr,
                       input bit expect_rsp);
    exp_t m;
    int   guard;
    logic acc;
    sel = s;
    m = model(op, addr, dw_of(s), s != 1);
    if (m.beats >= 1) exp_addr_q.push_back(m.a1);
    if (m.beats == 2) exp_addr_q.push_back(m.a2);
    if (expect_rsp) exp_q.push_back(m);
    c_req_op = op; c_req_addr = addr; c_req_valid = 1'b1;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 50) begin
      @(posedge clk);
      acc = c_req_ready;
      guard++;
    end
    #1;
    c_req_valid = 1'b0;
    if (!acc) check("accept_timeout", acc, 1);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("done_timeout", exp_q.size(), 0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, c_req_ready, 1);
    check({tag, "_mem_req_valid"}, c_mem_req_valid, 0);
    check({tag, "_mem_addr"}, c_mem_addr, 0);
    check({tag, "_rsp_valid"}, c_rsp_valid, 0);
    check({tag, "_rsp_data"}, c_rsp_data, 0);
    check({tag, "_rsp_err"}, c_rsp_err, 0);
  endtask

  initial begin
    exp_t m;
    int   b0;
    int   g;
    rst = 1'b1; sel = 0; c_req_valid = 1'b0; c_req_op = '0; c_req_addr = '0;
    c_mem_req_ready = 1'b1; c_rsp_ready = 1'b1; spur_valid = 1'b0;
    spur_rdata = '0; hold_rsp = 1'b0;
    repeat (3) tick();
    sel = 0; #1; check_reset_outputs("rst_dw32");
    sel = 2; #1; check_reset_outputs("rst_dw64");
    rst = 1'b0;
    tick();

    // signed byte from the top lane
    mem[32'h1000] = 64'h0000_0000_80FF_FF7F;
    m = model(ME_LB, 32'h1003, 32, 1);
    check("model_lb", m.data, 64'hFFFF_FF80);
    b0 = n_beats;
    issue(0, ME_LB, 32'h1003, 1); wait_done();
    check("lb_data", last_data, 64'hFFFF_FF80);
    check("lb_err", last_err, 0);
    check("lb_beats", n_beats - b0, 1);
    check("lb_addr", last_beat_addr, 32'h1000);

    // split halfword
    mem[32'h2000] = 64'h0000_0000_AB00_0000;
    mem[32'h2004] = 64'h0000_0000_0000_00CD;
    b0 = n_beats;
    issue(0, ME_LHU, 32'h2003, 1); wait_done();
    check("lhu_split_data", last_data, 64'h0000_CDAB);
    check("lhu_split_beats", n_beats - b0, 2);
    check("lhu_split_addr2", last_beat_addr, 32'h2004);

    // split refused: error one cycle after accept, no memory traffic
    b0 = n_beats;
    issue(1, ME_LW, 32'h3002, 1);
    check("err_rsp_valid_t1", c_rsp_valid, 1);
    check("err_rsp_err", c_rsp_err, 1);
    check("err_rsp_data", c_rsp_data, 0);
    check("err_no_mem_req", c_mem_req_valid, 0);
    wait_done();
    check("err_beats", n_beats - b0, 0);

    // DW=64 word loads from the upper half
    mem[32'h4000] = 64'h8765_4321_0000_0000;
    m = model(ME_LW, 32'h4004, 64, 1);
    check("model_lw64", m.data, 64'hFFFF_FFFF_8765_4321);
    issue(2, ME_LWU, 32'h4004, 1); wait_done();
    check("lwu64_data", last_data, 64'h0000_0000_8765_4321);
    issue(2, ME_LW, 32'h4004, 1); wait_done();
    check("lw64_data", last_data, 64'hFFFF_FFFF_8765_4321);

    // zero-wait aligned latency
    issue(0, ME_LW, 32'h1000, 1);
    check("lat_mem_req_t1", c_mem_req_valid, 1);
    tick();
    check("lat_wait1_no_rsp", c_rsp_valid, 0);
    tick();
    check("lat_rsp_valid", c_rsp_valid, 1);
    wait_done();

    // stray response while idle
    sel = 0; spur_valid = 1'b1; spur_rdata = 64'h1234_5678_9ABC_DEF0;
    tick(); spur_valid = 1'b0; tick();
    check("idle_spur_rsp_valid", c_rsp_valid, 0);
    check("idle_spur_req_ready", c_req_ready, 1);

    // backpressure on both channels
    c_mem_req_ready = 1'b0; c_rsp_ready = 1'b0;
    m = model(ME_LW, 32'h5000, 32, 1);
    issue(0, ME_LW, 32'h5000, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_req_ready", c_req_ready, 0);
      check("bp_mem_valid", c_mem_req_valid, 1);
      check("bp_mem_addr", c_mem_addr, 32'h5000);
      spur_valid = (i == 1); spur_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
    end
    spur_valid = 1'b0; c_mem_req_ready = 1'b1;
    g = 0;
    while (!c_rsp_valid && g < 20) begin tick(); g++; end
    check("bp_rsp_arrives", c_rsp_valid, 1);
    for (int i = 0; i < 2; i++) begin
      check("bp_hold_valid", c_rsp_valid, 1);
      check("bp_hold_req_ready", c_req_ready, 0);
      check("bp_hold_data", c_rsp_data, m.data);
      tick();
    end
    c_rsp_ready = 1'b1;
    check("bp_ready_same_cycle", c_req_ready, 0);
    tick();
    check("bp_ready_after", c_req_ready, 1);
    check("bp_valid_after", c_rsp_valid, 0);
    wait_done();

    // reset while waiting for the first beat, then a late response
    hold_rsp = 1'b1;
    issue(0, ME_LW, 32'h6000, 0);
    tick();
    check("rst_mid_wait1_mem_valid", c_mem_req_valid, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_outputs("rst_mid");
    hold_rsp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("late_rsp_valid", c_rsp_valid, 0);
      check("late_req_ready", c_req_ready, 1);
    end

    // address wrap on the second beat
    b0 = n_beats;
    issue(0, ME_LW, 32'hFFFF_FFFE, 1); wait_done();
    check("wrap_beats", n_beats - b0, 2);
    check("wrap_addr2", last_beat_addr, 32'h0000_0000);

    // every opcode at every offset in every configuration
    for (int s = 0; s < 3; s++)
      for (int op = 0; op < 8; op++)
        for (int off = 0; off < dw_of(s) / 8; off++) begin
          issue(s, 3'(op), 32'h8000 + 32'(s * 512 + op * 32 + off), 1);
          wait_done();
        end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_aligner.md
LOAD_ALIGNER -- requirements
Module: load_aligner

Interface
REQ-001 SHALL have parameter DW, default 32, memory/result data width; legal values 32 or 64.
REQ-002 SHALL have parameter ALLOW_UNALIGNED, default 1; 1 = boundary-crossing loads split into two beats, 0 = such loads return an error.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_op in 3 (load opcode), req_addr in 32 (byte address): the load request channel.
REQ-006 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_addr out 32 (always DW/8-aligned): the memory request channel.
REQ-007 SHALL have ports mem_rsp_valid in 1, mem_rdata in DW: the memory response channel, with no backpressure.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out DW, rsp_err out 1: the result channel.

Function
REQ-009 SHALL support opcodes LW, LH, LHU, LB, LBU; when DW=64, SHALL also support LWU and LD.
- Signed ops sign-extend from the top loaded bit; unsigned ops zero-extend to DW.
- LW with DW=64 sign-extends.
REQ-010 SHALL use little-endian byte lanes: byte k of the access is mem_rdata[8k+7:8k], with k = req_addr mod DW/8.
REQ-011 SHALL accept a request only when req_valid and req_ready are both 1; req_ready SHALL be 1 only in state IDLE.
REQ-012 SHALL implement states IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE:
- IDLE -> REQ1 on accept.
- REQ1 -> WAIT1 on mem handshake.
- WAIT1 -> REQ2 on mem_rsp_valid if the access is split, else -> DONE.
- REQ2 -> WAIT2 on mem handshake.
- WAIT2 -> DONE on mem_rsp_valid.
- DONE -> IDLE when rsp_ready=1.
REQ-013 SHALL assert mem_req_valid only in REQ1 and REQ2 and SHALL hold mem_addr stable while mem_req_ready=0.
- REQ1: mem_addr = req_addr with the low log2(DW/8) bits cleared.
- REQ2: mem_addr = the REQ1 address + DW/8, wrapping modulo 2^32.
REQ-014 SHALL treat an access as split when (addr mod DW/8) + size > DW/8. Byte loads are never split.
REQ-015 SHALL, for a split access, take the low bytes from beat 1 upper lanes and the high bytes from beat 2 lower lanes.
REQ-016 SHALL drive rsp_valid=1 only in DONE and SHALL hold rsp_data and rsp_err stable until rsp_ready=1.
REQ-017 SHALL raise rsp_err=1 with rsp_data=0 and issue no memory request in these cases; the request goes IDLE -> DONE directly:
- illegal opcode (including LWU/LD when DW=32);
- a split access when ALLOW_UNALIGNED=0.
REQ-018 SHALL ignore mem_rsp_valid in every state other than WAIT1 and WAIT2.
REQ-019 SHALL have these latencies, with the accept cycle as T and zero memory wait:
- aligned load: mem_req_valid at T+1; rsp_valid one cycle after mem_rsp_valid;
- error response: rsp_valid at T+1.
REQ-020 SHALL register rsp_data, so that no combinational path exists from mem_rdata to rsp_data.

Reset
REQ-021 SHALL, on rst=1, enter IDLE and drive req_ready=1, mem_req_valid=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-022 SHALL, on reset mid-operation, abandon the access without producing any response; a late mem_rsp_valid afterwards SHALL be ignored per REQ-018.

Structure
REQ-023 SHALL take opcode encodings (ME_LW=0, ME_LH=1, ME_LHU=2, ME_LB=3, ME_LBU=4, ME_LWU=5, ME_LD=6) and state encodings from the shared public definitions package.
REQ-024 SHALL contain one combinational sub-module, load_extract, that maps (op, byte offset, DW or 2*DW merged data) to the extended result; the FSM and registers SHALL remain in load_aligner.

Verification
REQ-025 DW=32, LB at address 0x1003, mem_rdata=0x80FF_FF7F -> rsp_data=0xFFFF_FF80, rsp_err=0, one memory beat at address 0x1000.
REQ-026 DW=32, LHU at 0x2003, ALLOW_UNALIGNED=1, beat 1 = 0xAB00_0000 and beat 2 = 0x0000_00CD -> two beats at 0x2000 and 0x2004; rsp_data=0x0000_CDAB.
REQ-027 DW=32, ALLOW_UNALIGNED=0, LW at 0x3002 -> no mem_req_valid; rsp_valid at T+1 with rsp_err=1 and rsp_data=0.
REQ-028 DW=64, LWU at 0x4004, mem_rdata=0x8765_4321_0000_0000 -> rsp_data=0x0000_0000_8765_4321; LW with the same data -> 0xFFFF_FFFF_8765_4321.
REQ-029 Backpressure: mem_req_ready=0 for 3 cycles, then rsp_ready=0 for 2 cycles -> mem_addr stable throughout; rsp_data stable throughout; req_ready=0 until the cycle after rsp_ready=1.
REQ-030 Assert rst in WAIT1, then pulse mem_rsp_valid -> IDLE with all outputs at their reset values and no rsp_valid; split access at 0xFFFF_FFFE -> beat-2 address 0x0000_0000.
